// File: rtl/spike_inject_8.sv
// spike_inject_8 - programmable spike injector for the 8-bit sample path.
// Passes din through with one cycle of latency and, when enabled, replaces
// one or two samples per interval with a saturated din +/- amp spike.
// spike_flag marks every injected output sample; spike_cnt counts events.
module spike_inject_8 #(
    parameter int          PERIOD_W  = 16,
    parameter int          JIT_W     = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          din,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    input  logic [7:0]          amp,
    input  logic                width2,
    input  logic                rand_en,
    input  logic                pol_neg,
    input  logic                pol_alt,
    input  logic                cnt_clr,
    output logic [7:0]          dout,
    output logic                spike_flag,
    output logic [15:0]         spike_cnt
);

    // Interval counter carries one extra bit so the jittered reload never wraps.
    localparam int CW = PERIOD_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_HIT1  = 2'd2,
        S_HIT2  = 2'd3
    } state_t;

    // Saturating add/subtract of the spike amplitude, widened to 9 bits.
    function automatic logic [7:0] spike_val(input logic [7:0] d,
                                             input logic [7:0] a,
                                             input logic       neg);
        logic [8:0] sum;
        logic [7:0] res;
        sum = {1'b0, d} + {1'b0, a};
        if (neg) begin
            res = (d > a) ? (d - a) : 8'd0;
        end else begin
            res = sum[8] ? 8'hFF : sum[7:0];
        end
        return res;
    endfunction

    state_t            state_r, state_n_s, state_d_s;
    logic [CW-1:0]     cnt_r, cnt_n_s;
    logic [15:0]       lfsr_r, lfsr_n_s;
    logic              tog_r, tog_n_s;
    logic              w2_r, w2_n_s;
    logic [7:0]        dout_r, dout_n_s;
    logic              flag_r, flag_n_s;
    logic [15:0]       spike_cnt_r, spike_cnt_n_s;
    logic              hit1_s;
    logic [PERIOD_W-1:0] pe_s;
    logic [JIT_W-1:0]  jit_s;
    logic [1:0]        dec_s;
    logic [CW:0]       sum_s;
    logic [CW-1:0]     reload_s;
    logic [7:0]        spike_s;

    // Reload value: clamped period minus the event length plus optional jitter.
    always_comb begin
        pe_s     = (period < PERIOD_W'(3)) ? PERIOD_W'(3) : period;
        dec_s    = width2 ? 2'd3 : 2'd2;
        jit_s    = rand_en ? lfsr_r[JIT_W-1:0] : {JIT_W{1'b0}};
        sum_s    = (CW+1)'(pe_s) - (CW+1)'(dec_s) + (CW+1)'(jit_s);
        reload_s = sum_s[CW] ? {CW{1'b1}} : sum_s[CW-1:0];
        spike_s  = spike_val(din, amp, pol_neg ^ (pol_alt & tog_r));
    end

    // Next-state and next-output logic of the injection sequencer.
    always_comb begin
        state_n_s = state_r;
        cnt_n_s   = cnt_r;
        w2_n_s    = w2_r;
        tog_n_s   = tog_r;
        dout_n_s  = din;
        flag_n_s  = 1'b0;
        hit1_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (en) begin
                    cnt_n_s   = reload_s;
                    w2_n_s    = width2;
                    state_n_s = S_COUNT;
                end else begin
                    state_n_s = S_IDLE;
                end
            end
            S_COUNT: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_n_s = S_HIT1;
                end else begin
                    cnt_n_s = cnt_r - CW'(1);
                end
            end
            S_HIT1: begin
                dout_n_s = spike_s;
                flag_n_s = 1'b1;
                hit1_s   = 1'b1;
                if (w2_r && en) begin
                    state_n_s = S_HIT2;
                end else begin
                    cnt_n_s   = reload_s;
                    w2_n_s    = width2;
                    tog_n_s   = tog_r ^ pol_alt;
                    state_n_s = S_COUNT;
                end
            end
            S_HIT2: begin
                dout_n_s  = spike_s;
                flag_n_s  = 1'b1;
                cnt_n_s   = reload_s;
                w2_n_s    = width2;
                tog_n_s   = tog_r ^ pol_alt;
                state_n_s = S_COUNT;
            end
            default: begin
                state_n_s = S_IDLE;
            end
        endcase
        // Dropping en always parks the sequencer after the current cycle.
        state_d_s = en ? state_n_s : S_IDLE;
    end

    // Event counter and LFSR next values.
    always_comb begin
        if (cnt_clr) begin
            spike_cnt_n_s = hit1_s ? 16'd1 : 16'd0;
        end else begin
            spike_cnt_n_s = spike_cnt_r + {15'd0, hit1_s};
        end
        if (en) begin
            lfsr_n_s = {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        end else begin
            lfsr_n_s = lfsr_r;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            cnt_r       <= {CW{1'b0}};
            lfsr_r      <= LFSR_SEED;
            tog_r       <= 1'b0;
            w2_r        <= 1'b0;
            dout_r      <= 8'd0;
            flag_r      <= 1'b0;
            spike_cnt_r <= 16'd0;
        end else begin
            state_r     <= state_d_s;
            cnt_r       <= cnt_n_s;
            lfsr_r      <= lfsr_n_s;
            tog_r       <= tog_n_s;
            w2_r        <= w2_n_s;
            dout_r      <= dout_n_s;
            flag_r      <= flag_n_s;
            spike_cnt_r <= spike_cnt_n_s;
        end
    end

    assign dout       = dout_r;
    assign spike_flag = flag_r;
    assign spike_cnt  = spike_cnt_r;

endmodule
